// File: rtl/mpu_pixel_feeder_if.sv
// Pixel feeder bus: the upstream valid/ready pixel port plus the MPU-engine de/rgb/ack port.
// With MPU_PIXEL_FEEDER_RGB565_EN defined, i_data is a 16-bit RGB565 pixel.
interface mpu_pixel_feeder_if #(
    parameter int IN_WIDTH   = 24,
    parameter int DATA_WIDTH = 24
);
`ifdef MPU_PIXEL_FEEDER_RGB565_EN
    logic [15:0]           i_data;
`else
    logic [IN_WIDTH-1:0]   i_data;
`endif
    logic                  i_valid;
    logic                  o_ready;
    logic                  o_de;
    logic [DATA_WIDTH-1:0] o_rgb;
    logic                  i_ack;

    modport master (
        output i_valid, i_data, i_ack,
        input  o_ready, o_de, o_rgb
    );

    modport slave (
        input  i_valid, i_data, i_ack,
        output o_ready, o_de, o_rgb
    );
endinterface

// File: rtl/mpu_pixel_feeder.sv
// Show-ahead pixel FIFO and frame sequencer feeding the NT35510 MPU write engine.
// Optional RGB565->RGB888 expansion at FIFO write: macro MPU_PIXEL_FEEDER_RGB565_EN.
//
// state    | meaning
// S_IDLE   | waiting for MPU engine init
// S_ARMED  | buffering; o_de raised once START_LEVEL pixels are queued
// S_STREAM | frame in progress, counting acks up to the latched frame length
module mpu_pixel_feeder #(
    parameter int DATA_WIDTH  = 24,
    parameter int IN_WIDTH    = 24,
    parameter int FIFO_AW     = 6,
    parameter int START_LEVEL = 16,
    parameter int PCNT_WIDTH  = 19
) (
    input  logic                  i_sysclk,
    input  logic                  i_arstn,
    input  logic                  i_init_done,
    input  logic [PCNT_WIDTH-1:0] i_frame_pixels,
    input  logic                  i_flush,
    mpu_pixel_feeder_if.slave     px,
    output logic [FIFO_AW:0]      o_level,
    output logic                  o_frame_done,
    output logic                  o_underrun,
    output logic                  o_overflow,
    output logic [1:0]            o_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam int DEPTH = 2 ** FIFO_AW;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr;
    logic [FIFO_AW-1:0]    rd_ptr;
    logic [FIFO_AW:0]      level;
    logic [DATA_WIDTH-1:0] rgb_q;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    logic [1:0]            state;
    logic [PCNT_WIDTH-1:0] pcnt;
    logic [PCNT_WIDTH-1:0] pcnt_inc;
    logic [PCNT_WIDTH-1:0] flen;
    logic                  done_q;
    logic                  de_q;
    logic                  underrun_q;
    logic                  overflow_q;

`ifdef MPU_PIXEL_FEEDER_RGB565_EN
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    assign r5      = px.i_data[15:11];
    assign g6      = px.i_data[10:5];
    assign b5      = px.i_data[4:0];
    assign wr_data = DATA_WIDTH'({r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]});
`else
    assign wr_data = DATA_WIDTH'(px.i_data);
`endif

    assign full     = (level == (FIFO_AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign push     = px.i_valid & ~full;
    assign pop      = px.i_ack & ~empty;
    assign pcnt_inc = pcnt + PCNT_WIDTH'(1);

    always_ff @(posedge i_sysclk) begin
        if (push && !i_flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // o_rgb is a register loaded with the new head, so it never reads a stale slot
    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rgb_q  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (FIFO_AW+1)'(1);
                2'b01:   level <= level - (FIFO_AW+1)'(1);
                default: level <= level;
            endcase
            if (push && (empty || (pop && level == (FIFO_AW+1)'(1)))) begin
                rgb_q <= wr_data;
            end else if (pop && level > (FIFO_AW+1)'(1)) begin
                rgb_q <= mem[rd_ptr + FIFO_AW'(1)];
            end
        end
    end

    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) begin
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else if (i_flush) begin
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (px.i_ack && empty)  underrun_q <= 1'b1;
            if (px.i_valid && full) overflow_q <= 1'b1;
        end
    end

    // Underrun acks still advance pcnt so frame boundaries track the MPU engine
    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) begin
            state  <= S_IDLE;
            pcnt   <= '0;
            flen   <= '0;
            done_q <= 1'b0;
            de_q   <= 1'b0;
        end else if (i_flush) begin
            state  <= S_IDLE;
            pcnt   <= '0;
            flen   <= '0;
            done_q <= 1'b0;
            de_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            de_q   <= (state == S_ARMED) && (level >= (FIFO_AW+1)'(START_LEVEL))
                      && i_init_done && !px.i_ack;
            case (state)
                S_IDLE: begin
                    if (i_init_done) state <= S_ARMED;
                end
                S_ARMED: begin
                    if (px.i_ack) begin
                        flen <= i_frame_pixels;
                        if (i_frame_pixels <= PCNT_WIDTH'(1)) begin
                            done_q <= 1'b1;
                            pcnt   <= '0;
                        end else begin
                            pcnt  <= PCNT_WIDTH'(1);
                            state <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (px.i_ack) begin
                        if (pcnt_inc == flen) begin
                            done_q <= 1'b1;
                            pcnt   <= '0;
                            state  <= S_ARMED;
                        end else begin
                            pcnt <= pcnt_inc;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign px.o_ready   = ~full;
    assign px.o_de      = de_q;
    assign px.o_rgb     = rgb_q;
    assign o_level      = level;
    assign o_frame_done = done_q;
    assign o_underrun   = underrun_q;
    assign o_overflow   = overflow_q;
    assign o_state      = state;

endmodule
